// File: rtl/cnn_inference_scheduler_if.sv
// Requester/response bus for cnn_inference_scheduler.
// master: requesters and result consumer; slave: the scheduler.
interface cnn_inference_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*5-1:0] req_index;
    logic [NUM_REQ-1:0]   req_pipeline;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [4:0]           rsp_index;
    logic [3:0]           rsp_digit;
    logic                 rsp_timeout;

    modport master (
        output req_valid, req_index, req_pipeline, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_index, rsp_digit, rsp_timeout
    );

    modport slave (
        input  req_valid, req_index, req_pipeline, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_index, rsp_digit, rsp_timeout
    );
endinterface

// File: rtl/cnn_inference_scheduler.sv
// Shares one MNIST CNN engine among NUM_REQ requesters: round-robin job
// intake into a FIFO, then a sequencer that resets, starts and waits on the
// engine for each job and returns {id, index, digit} on the response port.
// Optional WAIT watchdog: define CNN_SCHED_TIMEOUT_EN.
module cnn_inference_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     resetn,
    cnn_inference_scheduler_if.slave bus,
    output logic                     eng_resetn,
    output logic                     eng_start,
    output logic [4:0]               eng_index,
    output logic                     eng_pipeline,
    input  logic                     eng_done,
    input  logic [3:0]               eng_digit,
    output logic                     busy,
    output logic [15:0]              jobs_done
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned RCW = $clog2(RST_CYCLES) + 1;

    localparam bit PARAMS_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) && (FIFO_DEPTH >= 2) &&
                               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) && (RST_CYCLES >= 1) &&
                               (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65536);
    if (!PARAMS_OK) begin : g_bad_params
        $error("cnn_inference_scheduler: unsupported parameter set");
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     index;
        logic           pipeline;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ENG_RST, S_ARM, S_START, S_WAIT, S_RESP
    } state_t;

    // FIFO and arbiter state
    job_t           fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] grant_vec;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;
    logic               push, pop;
    job_t               push_job, head_job;

    // Sequencer state and registered outputs
    state_t         state_q;
    logic           internal_rstn_q;
    logic [RCW-1:0] rst_cnt_q;
    job_t           job_q;
    logic           eng_start_q, eng_pipeline_q;
    logic [4:0]     eng_index_q;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [4:0]     rsp_index_q;
    logic [3:0]     rsp_digit_q;
    logic [15:0]    jobs_done_q;
`ifdef CNN_SCHED_TIMEOUT_EN
    logic [15:0]    wd_cnt_q;
    logic           rsp_timeout_q;
`endif

    // Round-robin grant: first valid requester at or after rr_ptr, only when FIFO has room
    always_comb begin
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (count_q != CW'(FIFO_DEPTH)) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && bus.req_valid[IDW'((32'(rr_ptr_q) + k) % NUM_REQ)]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
                end
            end
        end
        if (grant_any) begin
            grant_vec[grant_id] = 1'b1;
        end
    end

    assign push              = grant_any;
    assign pop               = (state_q == S_IDLE) && (count_q != '0);
    assign head_job          = fifo_mem_q[rd_ptr_q];
    assign push_job.id       = grant_id;
    assign push_job.index    = bus.req_index[32'(grant_id) * 5 +: 5];
    assign push_job.pipeline = bus.req_pipeline[grant_id];

    // Next-state for FIFO pointers, occupancy and round-robin pointer
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // FIFO bookkeeping registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FIFO storage, written at the tail on each accepted request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_job;
        end
    end

    // Job sequencer: engine reset pulse, start pulse, wait for done, hold response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            internal_rstn_q <= 1'b1;
            rst_cnt_q       <= '0;
            job_q           <= '0;
            eng_start_q     <= 1'b0;
            eng_index_q     <= '0;
            eng_pipeline_q  <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_index_q     <= '0;
            rsp_digit_q     <= '0;
            jobs_done_q     <= '0;
`ifdef CNN_SCHED_TIMEOUT_EN
            wd_cnt_q        <= '0;
            rsp_timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        job_q           <= head_job;
                        internal_rstn_q <= 1'b0;
                        rst_cnt_q       <= '0;
                        state_q         <= S_ENG_RST;
                    end
                end
                S_ENG_RST: begin
                    if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                        internal_rstn_q <= 1'b1;
                        eng_index_q     <= job_q.index;
                        eng_pipeline_q  <= job_q.pipeline;
                        state_q         <= S_ARM;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RCW'(1);
                    end
                end
                S_ARM: begin
                    eng_start_q <= 1'b1;
                    state_q     <= S_START;
                end
                S_START: begin
                    eng_start_q <= 1'b0;
`ifdef CNN_SCHED_TIMEOUT_EN
                    wd_cnt_q    <= '0;
`endif
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= job_q.id;
                        rsp_index_q   <= job_q.index;
                        rsp_digit_q   <= eng_digit;
                        jobs_done_q   <= jobs_done_q + 16'd1;
`ifdef CNN_SCHED_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q       <= S_RESP;
                    end
`ifdef CNN_SCHED_TIMEOUT_EN
                    // done has priority over an expiry in the same cycle
                    else if (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_id_q      <= job_q.id;
                        rsp_index_q   <= job_q.index;
                        rsp_digit_q   <= 4'hF;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = grant_vec;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_index   = rsp_index_q;
    assign bus.rsp_digit   = rsp_digit_q;
`ifdef CNN_SCHED_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign eng_resetn   = resetn & internal_rstn_q;
    assign eng_start    = eng_start_q;
    assign eng_index    = eng_index_q;
    assign eng_pipeline = eng_pipeline_q;
    assign busy         = (state_q != S_IDLE) || (count_q != '0);
    assign jobs_done    = jobs_done_q;
endmodule

// File: tb/tb_cnn_inference_scheduler.sv
// Testbench for cnn_inference_scheduler: requester driver, engine model,
// and a job-timeline reference model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_cnn_inference_scheduler;
    localparam int NR = 4;
    localparam int FD = 4;
    localparam int RC = 2;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        eng_resetn, eng_start, eng_pipeline, busy;
    logic [4:0]  eng_index;
    logic        eng_done = 1'b0;
    logic [3:0]  eng_digit = 4'd0;
    logic [15:0] jobs_done;

    cnn_inference_scheduler_if #(.NUM_REQ(NR)) bus ();

    cnn_inference_scheduler #(
        .NUM_REQ(NR), .FIFO_DEPTH(FD), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .eng_resetn(eng_resetn), .eng_start(eng_start), .eng_index(eng_index),
        .eng_pipeline(eng_pipeline), .eng_done(eng_done), .eng_digit(eng_digit),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- requester driver ----------------
    int         req_cnt [NR];
    logic [4:0] req_idx_cfg [NR];
    int         gnt_log_id [$];
    int         gnt_log_cyc [$];

    initial begin
        logic [NR-1:0] g;
        for (int r = 0; r < NR; r++) begin req_cnt[r] = 0; req_idx_cfg[r] = 5'(r); end
        bus.req_valid = '0; bus.req_index = '0; bus.req_pipeline = '0; bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            g = bus.req_valid & bus.req_ready;
            for (int r = 0; r < NR; r++)
                if (g[r] && resetn) begin gnt_log_id.push_back(r); gnt_log_cyc.push_back(cyc); end
            @(posedge clk); #1;
            for (int r = 0; r < NR; r++) begin
                if (g[r] && req_cnt[r] > 0) req_cnt[r]--;
                bus.req_valid[r]        = resetn && (req_cnt[r] > 0);
                bus.req_index[5*r +: 5] = req_idx_cfg[r];
                bus.req_pipeline[r]     = r[0];
            end
        end
    end

    // ---------------- engine model ----------------
    int eng_delay = 0;          // 0: never signals done
    int eng_digit_cfg = 0;

    initial begin
        int cnt; bit st;
        cnt = 0;
        forever begin
            @(negedge clk);
            st = (eng_start === 1'b1);
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (!resetn) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin eng_done = 1'b1; eng_digit = 4'(eng_digit_cfg); end
                end
                if (st && eng_delay > 0) cnt = eng_delay;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct { int id; int idx; int pipe; } mjob_t;
    mjob_t mq [$];
    int    m_rr, m_age, m_rdig, m_done_cnt;
    bit    m_active, m_rsp, m_rto;
    mjob_t m_job, m_rj;

    task automatic model_cycle();
        logic [NR-1:0] exp_gnt;
        int gid, a;
        bit pop_now, found;
        mjob_t nj;
        if (!resetn) begin
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_eng_resetn", eng_resetn, 0);
            check("rst_eng_start", eng_start, 0);
            check("rst_eng_index", eng_index, 0);
            check("rst_jobs_done", jobs_done, 0);
            check("rst_rsp_timeout", bus.rsp_timeout, 0);
            mq.delete(); m_rr = 0; m_active = 0; m_rsp = 0; m_rto = 0; m_done_cnt = 0; m_age = 0;
            return;
        end
        exp_gnt = '0; gid = 0; found = 0;
        if (mq.size() < FD)
            for (int k = 0; k < NR; k++)
                if (!found && bus.req_valid[(m_rr + k) % NR]) begin
                    found = 1; gid = (m_rr + k) % NR; exp_gnt[gid] = 1'b1;
                end
        pop_now = !m_active && !m_rsp && (mq.size() > 0);
        check("req_ready", bus.req_ready, exp_gnt);
        check("busy", busy, m_active || m_rsp || (mq.size() > 0));
        check("eng_resetn", eng_resetn, !(m_active && m_age >= 1 && m_age <= RC));
        check("eng_start", eng_start, m_active && (m_age == RC + 2));
        if (m_active && m_age >= RC + 1) begin
            check("eng_index", eng_index, m_job.idx);
            check("eng_pipeline", eng_pipeline, m_job.pipe);
        end
        check("rsp_valid", bus.rsp_valid, m_rsp);
        if (m_rsp) begin
            check("rsp_id", bus.rsp_id, m_rj.id);
            check("rsp_index", bus.rsp_index, m_rj.idx);
            check("rsp_digit", bus.rsp_digit, m_rdig);
            check("rsp_timeout", bus.rsp_timeout, m_rto);
        end
        check("jobs_done", jobs_done, m_done_cnt & 16'hFFFF);

        a = m_age;
        if (m_active) m_age++;
        if (m_rsp && bus.rsp_ready) m_rsp = 0;
        if (m_active && a >= RC + 3) begin
            if (eng_done) begin
                m_rsp = 1; m_rj = m_job; m_rdig = eng_digit; m_rto = 0; m_done_cnt++; m_active = 0;
            end
`ifdef CNN_SCHED_TIMEOUT_EN
            else if (a - (RC + 3) == TO - 1) begin
                m_rsp = 1; m_rj = m_job; m_rdig = 15; m_rto = 1; m_active = 0;
            end
`endif
        end
        if (pop_now) begin m_job = mq.pop_front(); m_active = 1; m_age = 1; end
        if (found) begin
            nj.id = gid; nj.idx = bus.req_index[5*gid +: 5]; nj.pipe = bus.req_pipeline[gid];
            mq.push_back(nj);
            m_rr = (gid + 1) % NR;
        end
    endtask

    initial forever begin @(negedge clk); model_cycle(); end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #2;
        resetn = 1'b0;
        for (int r = 0; r < NR; r++) req_cnt[r] = 0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        gnt_log_id.delete(); gnt_log_cyc.delete();
        resetn = 1'b1;
    endtask

    // which: 0 = eng_start, 1 = rsp_valid
    task automatic wait_sig(input int which, input int lim, input string name, output int at);
        bit hit;
        hit = 0; at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if ((which == 0 && eng_start === 1'b1) || (which == 1 && bus.rsp_valid === 1'b1)) begin
                hit = 1; at = cyc; break;
            end
        end
        check(name, hit, 1);
    endtask

    task automatic wait_grants(input int n, input int lim, input string name);
        for (int i = 0; i < lim && gnt_log_id.size() < n; i++) begin @(negedge clk); #1; end
        check(name, gnt_log_id.size() >= n, 1);
    endtask

    initial begin
        int s, v, h;
        logic [3:0] d0; logic [4:0] x0; logic [1:0] i0;
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s, v, h;
        logic [4:0] x0; logic [3:0] d0; logic [1:0] i0;

        // Single job: req0 index 3, digit 7
        do_reset();
        eng_delay = 50; eng_digit_cfg = 7; req_idx_cfg[0] = 5'd3; req_cnt[0] = 1;
        wait_sig(0, 50, "single_start_seen", s);
        check("single_grant_logged", gnt_log_id.size(), 1);
        if (gnt_log_cyc.size() > 0) check("single_start_latency", s - gnt_log_cyc[0], 1 + RC + 2);
        wait_sig(1, 100, "single_rsp_seen", v);
        check("single_rsp_id", bus.rsp_id, 0);
        check("single_rsp_index", bus.rsp_index, 3);
        check("single_rsp_digit", bus.rsp_digit, 7);
        @(negedge clk);
        check("single_jobs_done", jobs_done, 1);

        // Fairness then full FIFO
        do_reset();
        eng_delay = 40; eng_digit_cfg = 2;
        for (int r = 0; r < NR; r++) req_idx_cfg[r] = 5'(10 + r);
        req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
        wait_grants(5, 20, "fair_five_grants");
        if (gnt_log_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("fair_order", gnt_log_id[i], (i == 4) ? 0 : i);
                check("fair_consecutive", gnt_log_cyc[i] - gnt_log_cyc[0], i);
            end
        end
        @(posedge clk); #2;
        req_cnt[1] = 1;
        repeat (10) begin
            @(negedge clk);
            check("full_req_ready_zero", bus.req_ready, 0);
        end
        wait_sig(1, 200, "full_rsp_seen", h);
        check("full_rsp_id", bus.rsp_id, 0);
        check("full_rsp_index", bus.rsp_index, 10);
        wait_grants(6, 20, "full_next_grant");
        if (gnt_log_id.size() >= 6) begin
            check("full_next_grant_id", gnt_log_id[5], 1);
            check("full_next_grant_cyc", gnt_log_cyc[5] - h, 2);
        end

        // Response backpressure
        do_reset();
        eng_delay = 5; eng_digit_cfg = 4; req_idx_cfg[2] = 5'd20;
        bus.rsp_ready = 1'b0; req_cnt[2] = 2;
        wait_sig(1, 100, "bp_rsp_seen", v);
        i0 = bus.rsp_id; x0 = bus.rsp_index; d0 = bus.rsp_digit;
        check("bp_rsp_id", i0, 2);
        check("bp_rsp_index", x0, 20);
        check("bp_rsp_digit", d0, 4);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_fields", {bus.rsp_id, bus.rsp_index, bus.rsp_digit}, {i0, x0, d0});
            check("bp_no_start", eng_start, 0);
            check("bp_jobs_done", jobs_done, 1);
        end
        @(posedge clk); #2;
        bus.rsp_ready = 1'b1; h = cyc;
        wait_sig(0, 30, "bp_next_start_seen", s);
        check("bp_next_start_cyc", s - h, 1 + RC + 2);

        // Reset in the middle of WAIT with two jobs queued
        do_reset();
        eng_delay = 0; req_idx_cfg[3] = 5'd5; req_cnt[3] = 3;
        wait_sig(0, 30, "rst_mid_start_seen", s);
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        @(posedge clk); #2;
        resetn = 1'b0;
        for (int r = 0; r < NR; r++) req_cnt[r] = 0;
        #1;
        check("rst_mid_busy_now", busy, 0);
        check("rst_mid_rsp_valid_now", bus.rsp_valid, 0);
        check("rst_mid_eng_resetn_now", eng_resetn, 0);
        repeat (2) @(posedge clk);
        #2; resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_fifo_empty", busy, 0);
            check("rst_mid_no_start", eng_start, 0);
            check("rst_mid_eng_released", eng_resetn, 1);
        end

`ifdef CNN_SCHED_TIMEOUT_EN
        // Watchdog: engine never completes
        do_reset();
        eng_delay = 0; req_idx_cfg[0] = 5'd9; req_cnt[0] = 1;
        wait_sig(0, 30, "to_start_seen", s);
        wait_sig(1, TO + 50, "to_rsp_seen", v);
        check("to_rsp_cyc", v - s, 1 + TO);
        check("to_rsp_timeout", bus.rsp_timeout, 1);
        check("to_rsp_digit", bus.rsp_digit, 4'hF);
        check("to_rsp_index", bus.rsp_index, 9);
        check("to_jobs_done", jobs_done, 0);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
